apple2_kbd_latch: RTL and testbench

// - Consumes the 8-bit USB HID usage code that Nios software writes to the keycode PIO.
// - Produces the Apple II+ keyboard register read by the 6502 core:
//   - $C000 data: bit7 = strobe, bits[6:0] = uppercase ASCII.
//   - $C010 access: clears the strobe.
// - Adds key-change detection, HID->ASCII translation and typematic auto-repeat.
// - Sits between the keycode PIO out_port and the Apple II soft-switch/IO decode.

---
 rtl/apple2_kbd_pkg.sv | 42 ++++
 rtl/apple2_hid_to_ascii.sv | 41 ++++
 rtl/apple2_kbd_latch.sv | 105 ++++++++++
 tb/tb_apple2_kbd_latch.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/apple2_kbd_pkg.sv
// rtl/apple2_kbd_pkg.sv - HID usage, ASCII and FSM constants for the Apple II keyboard latch
package apple2_kbd_pkg;

    localparam logic [7:0] HID_NONE  = 8'h00;
    localparam logic [7:0] HID_A     = 8'h04;
    localparam logic [7:0] HID_Z     = 8'h1D;
    localparam logic [7:0] HID_1     = 8'h1E;
    localparam logic [7:0] HID_9     = 8'h26;
    localparam logic [7:0] HID_0     = 8'h27;
    localparam logic [7:0] HID_ENTER = 8'h28;
    localparam logic [7:0] HID_ESC   = 8'h29;
    localparam logic [7:0] HID_BKSP  = 8'h2A;
    localparam logic [7:0] HID_SPACE = 8'h2C;
    localparam logic [7:0] HID_MINUS = 8'h2D;
    localparam logic [7:0] HID_SEMI  = 8'h33;
    localparam logic [7:0] HID_COMMA = 8'h36;
    localparam logic [7:0] HID_DOT   = 8'h37;
    localparam logic [7:0] HID_SLASH = 8'h38;
    localparam logic [7:0] HID_RIGHT = 8'h4F;
    localparam logic [7:0] HID_LEFT  = 8'h50;

    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_1     = 8'h31;
    localparam logic [6:0] ASCII_0     = 7'h30;
    localparam logic [6:0] ASCII_CR    = 7'h0D;
    localparam logic [6:0] ASCII_ESC   = 7'h1B;
    localparam logic [6:0] ASCII_BS    = 7'h08;
    localparam logic [6:0] ASCII_SPACE = 7'h20;
    localparam logic [6:0] ASCII_NAK   = 7'h15;
    localparam logic [6:0] ASCII_MINUS = 7'h2D;
    localparam logic [6:0] ASCII_SEMI  = 7'h3B;
    localparam logic [6:0] ASCII_COMMA = 7'h2C;
    localparam logic [6:0] ASCII_DOT   = 7'h2E;
    localparam logic [6:0] ASCII_SLASH = 7'h2F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } kbd_state_e;

endpackage

// File: rtl/apple2_hid_to_ascii.sv
// rtl/apple2_hid_to_ascii.sv - combinational HID usage to Apple II+ uppercase ASCII translation
module apple2_hid_to_ascii
    import apple2_kbd_pkg::*;
(
    input  logic [7:0] keycode,
    output logic       valid,
    output logic [6:0] ascii
);

    logic [7:0] offset_code;

    always_comb begin
        valid       = 1'b1;
        ascii       = 7'h00;
        offset_code = 8'h00;
        if (keycode >= HID_A && keycode <= HID_Z) begin
            offset_code = keycode - HID_A + ASCII_A;
            ascii       = offset_code[6:0];
        end else if (keycode >= HID_1 && keycode <= HID_9) begin
            offset_code = keycode - HID_1 + ASCII_1;
            ascii       = offset_code[6:0];
        end else begin
            case (keycode)
                HID_0:     ascii = ASCII_0;
                HID_ENTER: ascii = ASCII_CR;
                HID_ESC:   ascii = ASCII_ESC;
                HID_BKSP:  ascii = ASCII_BS;
                HID_SPACE: ascii = ASCII_SPACE;
                HID_RIGHT: ascii = ASCII_NAK;
                HID_LEFT:  ascii = ASCII_BS;
                HID_MINUS: ascii = ASCII_MINUS;
                HID_SEMI:  ascii = ASCII_SEMI;
                HID_COMMA: ascii = ASCII_COMMA;
                HID_DOT:   ascii = ASCII_DOT;
                HID_SLASH: ascii = ASCII_SLASH;
                default:   valid = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/apple2_kbd_latch.sv
// rtl/apple2_kbd_latch.sv - Apple II+ $C000/$C010 keyboard latch with change detect and auto-repeat
module apple2_kbd_latch
    import apple2_kbd_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 2_500_000,
    parameter int unsigned CNT_W         = 25
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] keycode,
    input  logic       strb_clr,
    output logic [7:0] kbd_data,
    output logic       akd
);

    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    kbd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       prev_kc_q, prev_kc_d;
    logic [7:0]       kbd_data_q, kbd_data_d;
    logic             akd_q, akd_d;

    logic       xl_valid;
    logic [6:0] xl_ascii;
    logic       key_new;
    logic       strobe_set;

    apple2_hid_to_ascii u_xlate (
        .keycode (keycode),
        .valid   (xl_valid),
        .ascii   (xl_ascii)
    );

    assign key_new = (keycode != prev_kc_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prev_kc_d  = keycode;
        akd_d      = (keycode != HID_NONE);
        kbd_data_d = kbd_data_q;
        strobe_set = 1'b0;

        if (key_new) begin
            cnt_d = '0;
            if (keycode != HID_NONE && xl_valid) begin
                kbd_data_d[6:0] = xl_ascii;
                strobe_set      = 1'b1;
                state_d         = ST_DELAY;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_DELAY: begin
                    if (cnt_q == DELAY_LAST) begin
                        strobe_set = 1'b1;
                        cnt_d      = '0;
                        state_d    = ST_REPEAT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (cnt_q == PERIOD_LAST) begin
                        strobe_set = 1'b1;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // A strobe being set outranks a simultaneous $C010 clear.
        kbd_data_d[7] = strobe_set | (kbd_data_q[7] & ~strb_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            prev_kc_q  <= 8'h00;
            kbd_data_q <= 8'h00;
            akd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prev_kc_q  <= prev_kc_d;
            kbd_data_q <= kbd_data_d;
            akd_q      <= akd_d;
        end
    end

    assign kbd_data = kbd_data_q;
    assign akd      = akd_q;

endmodule

// File: tb/tb_apple2_kbd_latch.sv
// tb/tb_apple2_kbd_latch.sv - directed self-checking bench for apple2_kbd_latch
module tb_apple2_kbd_latch;

    logic       clk;
    logic       reset_n;
    logic [7:0] keycode;
    logic       strb_clr;
    logic [7:0] kbd_data;
    logic       akd;

    int n_checks = 0;
    int n_errors = 0;

    apple2_kbd_latch #(
        .REPEAT_DELAY  (8),
        .REPEAT_PERIOD (4),
        .CNT_W         (25)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .keycode  (keycode),
        .strb_clr (strb_clr),
        .kbd_data (kbd_data),
        .akd      (akd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_pulse();
        strb_clr = 1'b1;
        tick();
        strb_clr = 1'b0;
    endtask

    logic saw_strobe;

    initial begin
        reset_n  = 1'b0;
        keycode  = 8'h04;
        strb_clr = 1'b0;
        tick(3);
        check("reset_kbd", kbd_data, 8'h00);
        check("reset_akd", {7'd0, akd}, 8'h00);

        // Release with a key already held: it counts as a change from 0x00
        reset_n = 1'b1;
        tick();
        check("rel_kbd", kbd_data, 8'hC1);
        check("rel_akd", {7'd0, akd}, 8'h01);

        keycode = 8'h00;
        tick();
        check("up_hold", kbd_data, 8'hC1);
        check("up_akd", {7'd0, akd}, 8'h00);
        keycode = 8'h04;
        tick();
        check("a_kbd", kbd_data, 8'hC1);
        check("a_akd", {7'd0, akd}, 8'h01);
        clr_pulse();
        check("a_clr", kbd_data, 8'h41);
        keycode = 8'h00;
        tick();
        check("a_up_kbd", kbd_data, 8'h41);
        check("a_up_akd", {7'd0, akd}, 8'h00);

        // Enter held: strobe at t0, repeats at t0+8, t0+12, t0+16
        keycode = 8'h28;
        tick();
        check("ent_t0", kbd_data, 8'h8D);
        clr_pulse();
        tick(6);
        check("ent_t7", kbd_data, 8'h0D);
        tick();
        check("ent_t8", kbd_data, 8'h8D);
        clr_pulse();
        tick(2);
        check("ent_t11", kbd_data, 8'h0D);
        tick();
        check("ent_t12", kbd_data, 8'h8D);
        clr_pulse();
        tick(2);
        check("ent_t15", kbd_data, 8'h0D);
        tick();
        check("ent_t16", kbd_data, 8'h8D);

        // Rollover A -> B without a release
        keycode = 8'h04;
        tick();
        check("roll_a", kbd_data, 8'hC1);
        clr_pulse();
        keycode = 8'h05;
        tick();
        check("roll_b", kbd_data, 8'hC2);
        clr_pulse();
        tick(6);
        check("roll_t7", kbd_data, 8'h42);
        tick();
        check("roll_t8", kbd_data, 8'hC2);

        // Unmapped key: latch holds, akd follows, no repeats
        keycode = 8'h04;
        tick();
        clr_pulse();
        check("f1_pre", kbd_data, 8'h41);
        keycode = 8'h3A;
        tick();
        check("f1_kbd", kbd_data, 8'h41);
        check("f1_akd", {7'd0, akd}, 8'h01);
        saw_strobe = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (kbd_data !== 8'h41) saw_strobe = 1'b1;
        end
        check("f1_no_repeat", {7'd0, saw_strobe}, 8'h00);

        // Clear coinciding with the first repeat fire loses to the fire
        keycode = 8'h04;
        tick();
        check("pri_t0", kbd_data, 8'hC1);
        clr_pulse();
        tick(6);
        check("pri_t7", kbd_data, 8'h41);
        strb_clr = 1'b1;
        tick();
        strb_clr = 1'b0;
        check("pri_t8", kbd_data, 8'hC1);

        // Asynchronous reset mid-REPEAT
        tick(2);
        reset_n = 1'b0;
        keycode = 8'h00;
        #1;
        check("mid_rst_kbd", kbd_data, 8'h00);
        check("mid_rst_akd", {7'd0, akd}, 8'h00);
        tick();
        reset_n = 1'b1;
        saw_strobe = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (kbd_data !== 8'h00) saw_strobe = 1'b1;
        end
        check("post_rst_quiet", {7'd0, saw_strobe}, 8'h00);
        keycode = 8'h05;
        tick();
        check("post_rst_key", kbd_data, 8'hC2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
